// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } lsu_state_e;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // Number of bytes touched by an access: 1, 2 or 4.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addr_lsb, input logic [2:0] funct3);
    case (funct3[1:0])
      2'b01:   return addr_lsb[0];
      2'b10:   return addr_lsb != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) return funct3 inside {FUNCT3_SB, FUNCT3_SH, FUNCT3_SW};
    return funct3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU};
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of a right-aligned raw load word according to the load funct3.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] raw_i,
  input  logic [2:0]        funct3_i,
  output logic [DWIDTH-1:0] data_o
);

  // Pick the access size from the LSBs and extend to the full width
  always_comb begin
    data_o = '0;
    case (funct3_i)
      FUNCT3_LB:  data_o = {{(DWIDTH-8){raw_i[7]}}, raw_i[7:0]};
      FUNCT3_LH:  data_o = {{(DWIDTH-16){raw_i[15]}}, raw_i[15:0]};
      FUNCT3_LW:  data_o = raw_i;
      FUNCT3_LBU: data_o = {{(DWIDTH-8){1'b0}}, raw_i[7:0]};
      FUNCT3_LHU: data_o = {{(DWIDTH-16){1'b0}}, raw_i[15:0]};
      default:    data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator from the MEM stage to a byte-addressable data memory.
// Memory returns the bytes starting at mem_addr_o in the LSBs of mem_data_i.
// Build option LSU_MISALIGN_SPLIT_EN: misaligned accesses are split into byte
// accesses instead of being rejected with rsp_err_o.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic [2:0]        req_funct3_i,
  output logic              rsp_valid_o,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  lsu_state_e        state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              we_q, we_d;
  logic              split_q, split_d;
  logic [1:0]        k_q, k_d;
  logic [DWIDTH-1:0] acc_q, acc_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0]        last_k;
  logic [AWIDTH-1:0] byte_addr;
  logic [7:0]        wbyte;
  logic [DWIDTH-1:0] raw_split;
  logic [DWIDTH-1:0] ext_raw;
  logic [DWIDTH-1:0] ext_data;
  logic              req_mis;

  assign last_k    = 2'(access_bytes(funct3_q) - 3'd1);
  assign byte_addr = addr_q + AWIDTH'(k_q);
  assign wbyte     = wdata_q[{k_q, 3'b000} +: 8];
  assign req_mis   = is_misaligned(req_addr_i[1:0], req_funct3_i);

  // Little-endian assembly: byte k of a split load lands in lane k
  always_comb begin
    raw_split = acc_q;
    raw_split[{k_q, 3'b000} +: 8] = mem_data_i[7:0];
  end

  assign ext_raw = split_q ? raw_split : mem_data_i;

  lsu_load_extend #(
    .DWIDTH(DWIDTH)
  ) u_load_extend (
    .raw_i   (ext_raw),
    .funct3_i(funct3_q),
    .data_o  (ext_data)
  );

  // Next-state, memory port drive and response outputs
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    funct3_d       = funct3_q;
    we_d           = we_q;
    split_d        = split_q;
    k_d            = k_q;
    acc_d          = acc_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    req_ready_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    mem_funct3_o   = '0;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          funct3_d = req_funct3_i;
          we_d     = req_we_i;
          split_d  = req_mis && SplitEn;
          k_d      = 2'd0;
          acc_d    = '0;
          if (!is_legal(req_we_i, req_funct3_i) || (req_mis && !SplitEn)) begin
            // Rejected without touching memory
            state_d     = StResp;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        mem_read_en_o  = ~we_q;
        mem_write_en_o = we_q;
        if (split_q) begin
          mem_addr_o   = byte_addr;
          mem_funct3_o = we_q ? FUNCT3_SB : FUNCT3_LBU;
          mem_data_o   = {{(DWIDTH-8){1'b0}}, wbyte};
        end else begin
          mem_addr_o   = addr_q;
          mem_funct3_o = funct3_q;
          mem_data_o   = wdata_q;
        end
        if (split_q && (k_q != last_k)) begin
          k_d   = k_q + 2'd1;
          acc_d = raw_split;
        end else begin
          state_d     = StResp;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? '0 : ext_data;
        end
      end
      StResp: begin
        rsp_valid_o = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Quiet the ports during the reset cycle itself
    if (rst) begin
      req_ready_o    = 1'b0;
      rsp_valid_o    = 1'b0;
      mem_addr_o     = '0;
      mem_data_o     = '0;
      mem_read_en_o  = 1'b0;
      mem_write_en_o = 1'b0;
      mem_funct3_o   = '0;
    end
  end

  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  // State and request registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      split_q     <= 1'b0;
      k_q         <= 2'd0;
      acc_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      split_q     <= split_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed table, corner sequences and
// random traffic against a byte-array reference model.
module tb_lsu_mem_initiator;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [2:0]  req_funct3_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_en_o;
  logic        mem_write_en_o;
  logic [2:0]  mem_funct3_o;
  logic [31:0] mem_data_i;

  int n_pass = 0;
  int n_total = 0;
  int excl_viol = 0;

  always #5 clk = ~clk;

  lsu_mem_initiator dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_funct3_i  (req_funct3_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_read_en_o (mem_read_en_o),
    .mem_write_en_o(mem_write_en_o),
    .mem_funct3_o  (mem_funct3_o),
    .mem_data_i    (mem_data_i)
  );

  // Device memory (64 KiB window, addresses alias modulo 2^16)
  logic [7:0]  dev_mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] ma;
  assign ma = mem_addr_o[15:0];
  assign mem_data_i = {dev_mem[ma + 16'd3], dev_mem[ma + 16'd2], dev_mem[ma + 16'd1], dev_mem[ma]};

  always @(posedge clk) begin
    if (mem_write_en_o) begin
      dev_mem[ma] <= mem_data_o[7:0];
      if (mem_funct3_o[1:0] != 2'b00) dev_mem[ma + 16'd1] <= mem_data_o[15:8];
      if (mem_funct3_o[1:0] == 2'b10) begin
        dev_mem[ma + 16'd2] <= mem_data_o[23:16];
        dev_mem[ma + 16'd3] <= mem_data_o[31:24];
      end
    end
  end

  always @(negedge clk) if (mem_read_en_o && mem_write_en_o) excl_viol++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Reference: plain arithmetic over the byte array, straight from the access rules
  function automatic void model(input bit we, input logic [31:0] a, input logic [31:0] w,
                                input logic [2:0] f3, output logic [31:0] rd, output bit err,
                                output int lat, output int nwr, output int nrd);
    int nb, cyc;
    bit legal, mis;
    logic [63:0] v;
    nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
    mis = (int'(a[1:0]) % nb) != 0;
    rd = '0; err = 1'b0; nwr = 0; nrd = 0;
    if (!legal || (mis && !SPLIT)) begin
      err = 1'b1;
      lat = 1;
      return;
    end
    cyc = mis ? nb : 1;
    lat = cyc + 1;
    if (we) begin
      nwr = cyc;
      for (int i = 0; i < nb; i++) ref_mem[16'(a + i)] = w[8*i +: 8];
    end else begin
      nrd = cyc;
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[16'(a + i)]) << (8 * i));
      if (!f3[2] && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
      rd = v[31:0];
    end
  endfunction

  // One request; latency counted in cycles after the accept edge
  task automatic xact(input bit we, input logic [31:0] a, input logic [31:0] w,
                      input logic [2:0] f3, output logic [31:0] rd, output bit err,
                      output int lat, output int nwr, output int nrd);
    @(negedge clk);
    chk("ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_wdata_i = w; req_funct3_i = f3;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    lat = -1; nwr = 0; nrd = 0; rd = 'x; err = 1'bx;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_write_en_o) nwr++;
      if (mem_read_en_o) nrd++;
      if (rsp_valid_o) begin
        lat = c; rd = rsp_rdata_o; err = rsp_err_o;
        break;
      end
    end
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] rd, mrd;
    bit err, merr;
    int lat, nwr, nrd, mlat, mnwr, mnrd, rv_seen;
    bit we;
    logic [2:0] f3;
    logic [31:0] a, w;

    for (int i = 0; i < 65536; i++) begin
      dev_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    {dev_mem[16'h13], dev_mem[16'h12], dev_mem[16'h11], dev_mem[16'h10]} = 32'hDEAD_BEEF;
    {ref_mem[16'h13], ref_mem[16'h12], ref_mem[16'h11], ref_mem[16'h10]} = 32'hDEAD_BEEF;

    tbl.push_back('{1'b0, 32'h0100_0010, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, 2});
    tbl.push_back('{1'b1, 32'h0100_0013, 32'h80, 3'b000, 32'h0, 1'b0, 2});
    tbl.push_back('{1'b0, 32'h0100_0013, 32'h0, 3'b000, 32'hFFFF_FF80, 1'b0, 2});
    tbl.push_back('{1'b0, 32'h0100_0013, 32'h0, 3'b100, 32'h0000_0080, 1'b0, 2});
    tbl.push_back('{1'b0, 32'h0100_0010, 32'h0, 3'b010, 32'h80AD_BEEF, 1'b0, 2});
    tbl.push_back('{1'b1, 32'h0100_0020, 32'h1122_3344, 3'b010, 32'h0, 1'b0, 2});
    tbl.push_back('{1'b0, 32'h0100_0020, 32'h0, 3'b010, 32'h1122_3344, 1'b0, 2});
    tbl.push_back('{1'b1, 32'h0100_0022, 32'h0000_AABB, 3'b001, 32'h0, 1'b0, 2});
    tbl.push_back('{1'b0, 32'h0100_0020, 32'h0, 3'b010, 32'hAABB_3344, 1'b0, 2});
    tbl.push_back('{1'b0, 32'h0100_0022, 32'h0, 3'b001, 32'hFFFF_AABB, 1'b0, 2});
    tbl.push_back('{1'b0, 32'h0100_0022, 32'h0, 3'b101, 32'h0000_AABB, 1'b0, 2});
    tbl.push_back('{1'b0, 32'h0100_0010, 32'h0, 3'b011, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b1, 32'h0100_0010, 32'h0, 3'b011, 32'h0, 1'b1, 1});
`ifdef LSU_MISALIGN_SPLIT_EN
    tbl.push_back('{1'b1, 32'h0100_0031, 32'hA1B2_C3D4, 3'b010, 32'h0, 1'b0, 5});
    tbl.push_back('{1'b0, 32'h0100_0031, 32'h0, 3'b010, 32'hA1B2_C3D4, 1'b0, 5});
    tbl.push_back('{1'b0, 32'h0100_0033, 32'h0, 3'b001, 32'hFFFF_A1B2, 1'b0, 3});
    tbl.push_back('{1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 3'b001, 32'h0, 1'b0, 3});
    tbl.push_back('{1'b0, 32'hFFFF_FFFF, 32'h0, 3'b101, 32'h0000_1234, 1'b0, 3});
`else
    tbl.push_back('{1'b1, 32'h0100_0031, 32'hA1B2_C3D4, 3'b010, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b0, 32'h0100_0031, 32'h0, 3'b010, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b0, 32'h0100_0033, 32'h0, 3'b001, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b0, 32'h0100_0034, 32'h0, 3'b010, 32'h0, 1'b0, 2});
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_enables", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready_o), 32'd1);
    chk("post_rst_rsp", {29'd0, rsp_valid_o, rsp_err_o, mem_write_en_o}, 32'd0);
    chk("post_rst_rdata", rsp_rdata_o, 32'd0);
    chk("post_rst_mem_addr", mem_addr_o, 32'd0);

    // Directed table
    foreach (tbl[i]) begin
      xact(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, rd, err, lat, nwr, nrd);
      model(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, mrd, merr, mlat, mnwr, mnrd);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_wr_cycles", i), 32'(nwr), 32'(mnwr));
    end
    // Response data holds after the pulse
    @(negedge clk);
    chk("rdata_hold", rsp_rdata_o, tbl[tbl.size()-1].exp_rd);
    chk("rsp_pulse_off", 32'(rsp_valid_o), 32'd0);

    // Request held valid while busy: second one accepted only once idle again
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h0100_0010; req_funct3_i = 3'b010;
    @(posedge clk); #1;
    req_addr_i = 32'h0100_0013; req_funct3_i = 3'b100;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("busy_ready_c%0d", c), 32'(req_ready_o), (c == 3) ? 32'd1 : 32'd0);
      if (c == 2) chk("busy_first_rdata", rsp_rdata_o, 32'h80AD_BEEF);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        lat = c; rd = rsp_rdata_o;
        break;
      end
    end
    chk("busy_second_lat", 32'(lat), 32'd2);
    chk("busy_second_rdata", rd, 32'h0000_0080);

    // Reset in the middle of an access: no response, enables drop in the reset cycle
    @(negedge clk);
`ifdef LSU_MISALIGN_SPLIT_EN
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h0100_0051;
    req_wdata_i = 32'h5566_7788; req_funct3_i = 3'b010;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`else
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h0100_0050;
    req_wdata_i = 32'h5566_7788; req_funct3_i = 3'b010;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_enables", {30'd0, mem_read_en_o, mem_write_en_o}, 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready_o), 32'd1);
    rv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid_o) rv_seen++;
      @(negedge clk);
    end
    chk("midrst_no_rsp", 32'(rv_seen), 32'd0);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("midrst_bytes", {dev_mem[16'h54], dev_mem[16'h53], dev_mem[16'h52], dev_mem[16'h51]},
        32'h0000_7788);
    ref_mem[16'h51] = 8'h88;
    ref_mem[16'h52] = 8'h77;
`else
    chk("midrst_bytes", {dev_mem[16'h53], dev_mem[16'h52], dev_mem[16'h51], dev_mem[16'h50]},
        32'h0000_0000);
`endif

    // Random traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h0100_0100 + 32'($urandom_range(0, 255));
      w  = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model(we, a, w, f3, mrd, merr, mlat, mnwr, mnrd);
      xact(we, a, w, f3, rd, err, lat, nwr, nrd);
      chk($sformatf("rnd%0d_rdata", i), rd, mrd);
      chk($sformatf("rnd%0d_err", i), 32'(err), 32'(merr));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(mlat));
      chk($sformatf("rnd%0d_cycles", i), {16'(nwr), 16'(nrd)}, {16'(mnwr), 16'(mnrd)});
    end

    chk("enables_exclusive", 32'(excl_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
